dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data-cache controller for the 5-stage RISC-V core.
- Serves MEM-stage loads and stores, and drives the pipeline-wide stall that freezes the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- On a miss it sequences the optional dirty-victim writeback and the line refill over a req/ack handshake to the off-chip data memory.
- Contains a tag/valid/dirty/data array sub-module.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_if.sv | 35 +++
 rtl/dcache_sram.sv | 59 +++++
 rtl/dcache_controller.sv | 150 +++++++++++++++
 tb/tb_dcache_controller.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared configuration, address-field widths, FSM state encoding and
// address helpers for the L1 data-cache controller.
//   LINES / LINE_W / ADDR_W : cache geometry (16 lines x 256 bits, 32-bit addresses)
//   OFFSET_W / WORD_SEL_W / INDEX_W / TAG_W : derived address-field widths
package dcache_pkg;

  localparam int unsigned LINES      = 16;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;

  localparam int unsigned OFFSET_W   = $clog2(LINE_W / 8);
  localparam int unsigned WORD_SEL_W = $clog2(LINE_W / WORD_W);
  localparam int unsigned INDEX_W    = $clog2(LINES);
  localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    COMPLETE  = 2'd3
  } state_e;

  // Clears the byte-offset field to form a line-aligned memory address.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the data cache.
//   slave  : the cache controller (serves cpu_*, masters mem_*)
//   master : the environment (MEM stage + off-chip data memory)
//   cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i -> access request
//   cpu_rdata_o/cpu_stall_o                   <- load data, pipeline stall
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o -> line transfer request
//   mem_rdata_i/mem_ack_i                     <- refill data, completion pulse
interface dcache_if;
  import dcache_pkg::*;

  logic                  cpu_req_i;
  logic                  cpu_we_i;
  logic [ADDR_W-1:0]     cpu_addr_i;
  logic [WORD_W-1:0]     cpu_wdata_i;
  logic [WORD_W-1:0]     cpu_rdata_o;
  logic                  cpu_stall_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [LINE_W-1:0]     mem_wdata_o;
  logic [LINE_W-1:0]     mem_rdata_i;
  logic                  mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/dcache_sram.sv
// Tag / valid / dirty / data storage for the direct-mapped cache.
// Combinational read by index; synchronous whole-line refill or word merge.
//   clk_i, rst_i      : clock, async active-high clear of valid/dirty only
//   idx_i             : line index shared by read and write
//   tag_o/valid_o/dirty_o/line_o : contents of the indexed line
//   line_we_i/line_tag_i/line_i  : refill (sets valid, clears dirty)
//   word_we_i/word_sel_i/word_i  : store merge (sets dirty)
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    idx_i,
  output logic [TAG_W-1:0]      tag_o,
  output logic                  valid_o,
  output logic                  dirty_o,
  output logic [LINE_W-1:0]     line_o,
  input  logic                  line_we_i,
  input  logic [TAG_W-1:0]      line_tag_i,
  input  logic [LINE_W-1:0]     line_i,
  input  logic                  word_we_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0]     word_i
);

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  // Status bits: the only state that reset touches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays keep their contents across reset.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      data_q[idx_i] <= line_i;
      tag_q[idx_i]  <= line_tag_i;
    end else if (word_we_i) begin
      data_q[idx_i][word_sel_i*WORD_W +: WORD_W] <= word_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data-cache controller.
// Hits complete with zero stall; misses stall the pipeline while the dirty
// victim is written back and the line refilled over mem req/ack.
//   clk_i, rst_i : clock, async active-high reset
//   bus (slave)  : cpu_* access port and mem_* line-transfer port
module dcache_controller
  import dcache_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  dcache_if.slave bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                req_we_q, req_we_d;
  logic [WORD_W-1:0]   req_wdata_q, req_wdata_d;
  logic                gap_q, gap_d;

  logic [ADDR_W-1:0]     acc_addr;
  logic                  acc_we;
  logic [WORD_W-1:0]     acc_wdata;
  logic [TAG_W-1:0]      acc_tag;
  logic [INDEX_W-1:0]    acc_idx;
  logic [WORD_SEL_W-1:0] acc_sel;

  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic                rd_dirty;
  logic [LINE_W-1:0]   rd_line;
  logic [WORD_W-1:0]   rd_word;
  logic                hit;
  logic                line_we;
  logic                word_we;
  logic                unused_addr_bits;

  // In IDLE the live request is looked up; afterwards only the latched copy.
  assign acc_addr  = (state_q == IDLE) ? bus.cpu_addr_i  : req_addr_q;
  assign acc_we    = (state_q == IDLE) ? bus.cpu_we_i    : req_we_q;
  assign acc_wdata = (state_q == IDLE) ? bus.cpu_wdata_i : req_wdata_q;
  assign acc_tag   = acc_addr[ADDR_W-1 -: TAG_W];
  assign acc_idx   = acc_addr[OFFSET_W +: INDEX_W];
  assign acc_sel   = acc_addr[OFFSET_W-1 -: WORD_SEL_W];
  assign unused_addr_bits = ^acc_addr[OFFSET_W-WORD_SEL_W-1:0];

  assign rd_word = rd_line[acc_sel*WORD_W +: WORD_W];
  assign hit     = rd_valid && (rd_tag == acc_tag);

  dcache_sram u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (acc_idx),
    .tag_o      (rd_tag),
    .valid_o    (rd_valid),
    .dirty_o    (rd_dirty),
    .line_o     (rd_line),
    .line_we_i  (line_we),
    .line_tag_i (acc_tag),
    .line_i     (bus.mem_rdata_i),
    .word_we_i  (word_we),
    .word_sel_i (acc_sel),
    .word_i     (acc_wdata)
  );

  // State and request latches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      gap_q       <= gap_d;
    end
  end

  // Next state, array write enables and all bus outputs.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    gap_d       = 1'b0;
    line_we     = 1'b0;
    word_we     = 1'b0;
    bus.cpu_stall_o = 1'b0;
    bus.cpu_rdata_o = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req_i && !rst_i) begin
          if (hit) begin
            if (acc_we) word_we = 1'b1;
            else        bus.cpu_rdata_o = rd_word;
          end else begin
            bus.cpu_stall_o = 1'b1;
            req_addr_d  = bus.cpu_addr_i;
            req_we_d    = bus.cpu_we_i;
            req_wdata_d = bus.cpu_wdata_i;
            state_d     = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        bus.cpu_stall_o = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {rd_tag, acc_idx, OFFSET_W'(0)};
        bus.mem_wdata_o = rd_line;
        if (bus.mem_ack_i) begin
          state_d = ALLOCATE;
          gap_d   = 1'b1;
        end
      end

      ALLOCATE: begin
        bus.cpu_stall_o = 1'b1;
        // One idle cycle after a writeback so memory sees a fresh request edge.
        if (!gap_q) begin
          bus.mem_req_o  = 1'b1;
          bus.mem_addr_o = line_align(req_addr_q);
          if (bus.mem_ack_i) begin
            line_we = 1'b1;
            state_d = COMPLETE;
          end
        end
      end

      COMPLETE: begin
        // Replay of the latched access against the freshly filled line.
        if (acc_we) word_we = 1'b1;
        else        bus.cpu_rdata_o = rd_word;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  dcache_if bus ();

  dcache_controller dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  logic [LINE_W-1:0] ref_mem  [int];
  logic [LINE_W-1:0] back_mem [int];
  logic [LINE_W-1:0] exp_rd_q [$];
  logic [LINE_W-1:0] exp_wb_q [$];

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base, input logic [31:0] pat);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 8; k++) l[k*WORD_W +: WORD_W] = pat + 32'(k);
    ref_mem[int'(base)]  = l;
    back_mem[int'(base)] = l;
  endtask

  // One CPU access held until the stall releases; memory acks on the n_ack-th
  // consecutive cycle of an asserted request.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int n_ack, input int exp_stall,
                        input logic exp_wb, input logic [31:0] wb_addr);
    logic [31:0]       la;
    logic [LINE_W-1:0] l;
    logic [31:0]       hold_addr;
    int s, stall_cnt, req_cnt, cyc;
    logic done;
    la = line_align(addr);
    s  = int'(addr[4:2]);
    stall_cnt = 0; req_cnt = 0; cyc = 0; done = 1'b0; hold_addr = '0;
    if (exp_wb) exp_wb_q.push_back(ref_mem[int'(wb_addr)]);
    l = ref_mem[int'(la)];
    if (!we) exp_rd_q.push_back(LINE_W'(l[s*WORD_W +: WORD_W]));
    else begin
      l[s*WORD_W +: WORD_W] = wdata;
      ref_mem[int'(la)] = l;
    end
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = we; bus.cpu_addr_i = addr; bus.cpu_wdata_i = wdata;
    while (!done && cyc < 200) begin
      #1;
      if (!bus.cpu_stall_o) begin
        done = 1'b1;
        chk("stall_cycles", LINE_W'(stall_cnt), LINE_W'(exp_stall));
        chk("req_idle_on_release", LINE_W'(bus.mem_req_o), LINE_W'(1'b0));
        if (!we) chk("rdata", LINE_W'(bus.cpu_rdata_o), exp_rd_q.pop_front());
      end else begin
        stall_cnt++;
        if (bus.mem_req_o) begin
          req_cnt++;
          if (req_cnt == 1) begin
            hold_addr = bus.mem_addr_o;
            if (bus.mem_we_o) chk("wb_addr", LINE_W'(bus.mem_addr_o), LINE_W'(wb_addr));
            else              chk("alloc_addr", LINE_W'(bus.mem_addr_o), LINE_W'(la));
          end
          if (req_cnt == n_ack) begin
            chk("req_addr_stable", LINE_W'(bus.mem_addr_o), LINE_W'(hold_addr));
            bus.mem_ack_i = 1'b1;
            if (bus.mem_we_o) begin
              chk("wb_line", bus.mem_wdata_o, exp_wb_q.pop_front());
              back_mem[int'(bus.mem_addr_o)] = bus.mem_wdata_o;
            end else begin
              bus.mem_rdata_i = back_mem[int'(bus.mem_addr_o)];
            end
            req_cnt = 0;
          end
        end else begin
          req_cnt = 0;
        end
      end
      @(posedge clk_i); #1;
      bus.mem_ack_i = 1'b0;
      if (done) bus.cpu_req_i = 1'b0;
      cyc++;
    end
    chk("access_done", LINE_W'(done), LINE_W'(1'b1));
    bus.cpu_req_i = 1'b0;
  endtask

  initial begin
    logic got;
    rst_i = 1'b1;
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_ack_i = 1'b0;
    fill(32'h0000_0040, 32'h1000);
    fill(32'h0000_0240, 32'h2000);
    fill(32'h0000_0100, 32'h3000);
    fill(32'h0000_0500, 32'h4000);

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_stall", LINE_W'(bus.cpu_stall_o), LINE_W'(1'b0));
    chk("rst_mem_req", LINE_W'(bus.mem_req_o), LINE_W'(1'b0));
    chk("rst_mem_we", LINE_W'(bus.mem_we_o), LINE_W'(1'b0));
    chk("rst_mem_addr", LINE_W'(bus.mem_addr_o), LINE_W'(0));
    chk("rst_mem_wdata", bus.mem_wdata_o, LINE_W'(0));
    chk("rst_rdata", LINE_W'(bus.cpu_rdata_o), LINE_W'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Clean miss, N=3 -> 4 stall cycles.
    access(1'b0, 32'h0000_0040, 32'h0, 3, 4, 1'b0, 32'h0);
    chk("valid2_after_fill", LINE_W'(dut.u_sram.valid_q[2]), LINE_W'(1'b1));
    chk("dirty2_after_fill", LINE_W'(dut.u_sram.dirty_q[2]), LINE_W'(1'b0));
    // Hits.
    access(1'b0, 32'h0000_0044, 32'h0, 3, 0, 1'b0, 32'h0);
    access(1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 3, 0, 1'b0, 32'h0);
    // Dirty conflict miss, N=3 -> 8 stall cycles.
    access(1'b0, 32'h0000_0248, 32'h0, 3, 8, 1'b1, 32'h0000_0040);

    // Reset in the middle of a refill.
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_0040;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.mem_req_o) begin
        got = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    chk("alloc_before_reset", LINE_W'(got), LINE_W'(1'b1));
    chk("alloc_is_read", LINE_W'(bus.mem_we_o), LINE_W'(1'b0));
    rst_i = 1'b1;
    bus.cpu_req_i = 1'b0;
    #1;
    chk("reset_drops_req", LINE_W'(bus.mem_req_o), LINE_W'(1'b0));
    chk("reset_drops_stall", LINE_W'(bus.cpu_stall_o), LINE_W'(1'b0));
    chk("reset_clears_valid", LINE_W'(dut.u_sram.valid_q), LINE_W'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Stray ack in IDLE with no request.
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack_i = 1'b1;
      #1;
      chk("idle_ack_no_req", LINE_W'(bus.mem_req_o), LINE_W'(1'b0));
      chk("idle_ack_state", LINE_W'(dut.state_q), LINE_W'(IDLE));
      @(posedge clk_i); #1;
    end
    bus.mem_ack_i = 1'b0;

    // Same address misses again after reset, N=2 -> 3 stall cycles.
    access(1'b0, 32'h0000_0040, 32'h0, 2, 3, 1'b0, 32'h0);
    // Store miss, merge in COMPLETE, then read it back.
    access(1'b1, 32'h0000_0100, 32'hCAFE_0001, 2, 3, 1'b0, 32'h0);
    access(1'b0, 32'h0000_0100, 32'h0, 1, 0, 1'b0, 32'h0);
    // Evict the merged line, N=1 -> 4 stall cycles.
    access(1'b0, 32'h0000_0500, 32'h0, 1, 4, 1'b1, 32'h0000_0100);
    // Store hit on the cycle right after COMPLETE, then read it back.
    access(1'b1, 32'h0000_0504, 32'h0000_55AA, 1, 0, 1'b0, 32'h0);
    access(1'b0, 32'h0000_0504, 32'h0, 1, 0, 1'b0, 32'h0);
    // Refetched line carries the earlier written-back store.
    access(1'b0, 32'h0000_0048, 32'h0, 1, 0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
